// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extender behind a two-entry register slice
// Optional macro IMMEXT_BRANCH_MODE_EN enables mode 3 (branch offset); otherwise mode 3 flags out_err.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int EXT_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [OUT_W-1:0]  skid_data;
  logic [TAG_W-1:0]  skid_tag;
  logic              skid_err;

  logic [OUT_W-1:0]  zext;
  logic [OUT_W-1:0]  sext;
  logic [OUT_W-1:0]  uext;
  logic [OUT_W-1:0]  ext_data;
  logic              ext_err;
  logic              accept;
  logic              deliver;

  assign zext = {{EXT_W{1'b0}}, in_imm};
  assign sext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
  assign uext = {in_imm, {EXT_W{1'b0}}};

  always_comb begin
    ext_data = zext;
    ext_err  = 1'b0;
    case (in_mode)
      2'd0: ext_data = zext;
      2'd1: ext_data = sext;
      2'd2: ext_data = uext;
      default: begin
`ifdef IMMEXT_BRANCH_MODE_EN
        ext_data = {sext[OUT_W-3:0], 2'b00};
`else
        // unsupported branch mode still flows through, flagged, with the sign result
        ext_data = sext;
        ext_err  = 1'b1;
`endif
      end
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_tag  <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_data  <= ext_data;
            out_tag   <= in_tag;
            out_err   <= ext_err;
            out_valid <= 1'b1;
            state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && !deliver) begin
            skid_data <= ext_data;
            skid_tag  <= in_tag;
            skid_err  <= ext_err;
            in_ready  <= 1'b0;
            state     <= S_FULL;
          end else if (accept) begin
            out_data <= ext_data;
            out_tag  <= in_tag;
            out_err  <= ext_err;
          end else if (deliver) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only the skid can refill the output register
          if (deliver) begin
            out_data <= skid_data;
            out_tag  <= skid_tag;
            out_err  <= skid_err;
            in_ready <= 1'b1;
            state    <= S_ONE;
          end
        end
        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed bench for imm_extend_pipe (default and IMMEXT_BRANCH_MODE_EN builds)
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [4:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sent, exp_tag, n_acc, n_del, edges;
    logic will_acc, will_del, prev_stall;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;

    vecs[0] = '{16'h8000, 2'd1, 5'd1, 32'hFFFF8000, 1'b0};
    vecs[1] = '{16'h8000, 2'd0, 5'd2, 32'h00008000, 1'b0};
    vecs[2] = '{16'h1234, 2'd2, 5'd3, 32'h12340000, 1'b0};
`ifdef IMMEXT_BRANCH_MODE_EN
    vecs[3] = '{16'hFFFF, 2'd3, 5'd4, 32'hFFFFFFFC, 1'b0};
    vecs[4] = '{16'h0004, 2'd3, 5'd5, 32'h00000010, 1'b0};
    vecs[8] = '{16'h8000, 2'd3, 5'd9, 32'hFFFE0000, 1'b0};
`else
    vecs[3] = '{16'hFFFF, 2'd3, 5'd4, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{16'h0004, 2'd3, 5'd5, 32'h00000004, 1'b1};
    vecs[8] = '{16'h8000, 2'd3, 5'd9, 32'hFFFF8000, 1'b1};
`endif
    vecs[5] = '{16'h7FFF, 2'd1, 5'd6, 32'h00007FFF, 1'b0};
    vecs[6] = '{16'hFFFF, 2'd2, 5'd7, 32'hFFFF0000, 1'b0};
    vecs[7] = '{16'hFFFF, 2'd0, 5'd8, 32'h0000FFFF, 1'b0};
    vecs[9] = '{16'h1234, 2'd1, 5'd31, 32'h00001234, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_err", out_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // table vectors, back to back with out_ready high
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_imm   = vecs[i].imm;
      in_mode  = vecs[i].mode;
      in_tag   = vecs[i].tag;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
      check($sformatf("vec%0d_err", i), out_err, vecs[i].exp_err);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("vec_drain_valid", out_valid, 0);

    // backpressure: tags 1..6, consumer stalled for the first 3 cycles
    in_mode = 2'd0;
    sent = 0; exp_tag = 1; prev_stall = 1'b0; prev_data = '0; prev_tag = '0;
    for (int cyc = 0; cyc < 40 && exp_tag <= 6; cyc++) begin
      if (prev_stall) begin
        check("bp_stable_data", out_data, prev_data);
        check("bp_stable_tag", out_tag, prev_tag);
      end
      if (cyc == 2) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid_held", out_valid, 1);
      end
      out_ready = (cyc >= 3);
      in_valid  = (sent < 6);
      in_tag    = 5'(sent + 1);
      in_imm    = 16'((sent + 1) * 16'h0111);
      will_acc  = in_valid && in_ready;
      will_del  = out_valid && out_ready;
      if (will_del) begin
        check("bp_tag_order", out_tag, 32'(exp_tag));
        check("bp_data", out_data, 32'(exp_tag * 32'h111));
        exp_tag++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
      @(posedge clk);
      if (will_acc) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_all_delivered", 32'(exp_tag), 7);
    check("bp_all_accepted", 32'(sent), 6);
    @(negedge clk);
    check("bp_drained", out_valid, 0);

    // full throughput: 100 beats, out_ready always high
    out_ready = 1'b1; in_mode = 2'd0;
    n_acc = 0; n_del = 0; edges = 0;
    while (n_del < 100 && edges < 300) begin
      in_valid = (n_acc < 100);
      in_imm   = 16'(n_acc);
      in_tag   = 5'(n_acc);
      will_acc = in_valid && in_ready;
      will_del = out_valid && out_ready;
      if (will_del && out_data !== 32'(n_del)) check("tp_data_order", out_data, 32'(n_del));
      @(posedge clk);
      edges++;
      if (will_acc) n_acc++;
      if (will_del) n_del++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("tp_deliveries", 32'(n_del), 100);
    check("tp_cycles", 32'(edges), 101);

    // reset while FULL
    @(negedge clk);
    out_ready = 1'b0; in_mode = 2'd1;
    in_valid = 1'b1; in_tag = 5'd1; in_imm = 16'h0001;
    @(negedge clk);
    in_tag = 5'd2; in_imm = 16'h0002;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_data", out_data, 0);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_tag = 5'd7; in_mode = 2'd1; in_imm = 16'h0007; out_ready = 1'b1;
    @(negedge clk);
    check("postrst_valid", out_valid, 1);
    check("postrst_tag", out_tag, 7);
    check("postrst_data", out_data, 32'h7);

    // mode 3 followed by mode 1: error flag is per beat
    in_mode = 2'd3; in_imm = 16'hFFFF; in_tag = 5'd9;
    @(negedge clk);
`ifdef IMMEXT_BRANCH_MODE_EN
    check("m3_data", out_data, 32'hFFFFFFFC);
    check("m3_err", out_err, 0);
`else
    check("m3_data", out_data, 32'hFFFFFFFF);
    check("m3_err", out_err, 1);
`endif
    check("m3_tag", out_tag, 9);
    in_mode = 2'd1; in_imm = 16'hFFFF; in_tag = 5'd10;
    @(negedge clk);
    check("m1_after_m3_data", out_data, 32'hFFFFFFFF);
    check("m1_after_m3_err", out_err, 0);
    check("m1_after_m3_tag", out_tag, 10);
    in_valid = 1'b0;
    @(negedge clk);
    check("final_drain", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
